mem_access: RTL and testbench
=============================

# mem_access

Memory-stage load/store unit sitting between EX and WB. It accepts one memory instruction at a time and runs a request/response handshake with the 32-bit data memory port. It stalls the pipeline while the access is in flight. Load results are delivered right-justified and raw (unsigned) to WB; WB does the sign extension.

## Interface
- No parameters; op3 encodings come from `sparc_pkg`.
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-low reset
- MEM_valid_in  in  1  EX presents a valid instruction this cycle
- MEM_op_in  in  2  SPARC op field; 2'b11 = memory format
- MEM_op3_in  in  6  op3 field
- MEM_addr_in  in  32  effective byte address from EX
- MEM_store_data_in  in  64  store data; [63:32] = even rd, [31:0] = odd rd (or single rd)
- MEM_stall  out  1  freeze IF/ID/EX
- MEM_done  out  1  one-cycle pulse: access complete, load data valid
- MEM_align_trap  out  1  one-cycle pulse: misaligned address, no access issued
- MEM_load_data_out  out  64  registered load result
- mem_req  out  1  request valid
- mem_we  out  1  1 = write
- mem_addr  out  32  word address, [1:0] = 0
- mem_be  out  4  byte enables; be[3] = byte offset 0 (big-endian)
- mem_wdata  out  32  write data
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  read data / write ack
- mem_rdata  in  32  read data

## Operation
- Supported op3: LD, LDUB, LDUH, LDD, LDSB, LDSH, ST, STB, STH, STD. Any other op3, or op != 2'b11, is a pass-through: no stall, no request.
- Alignment rules:
  - half ops: addr[0] must be 0
  - LD/ST: addr[1:0] must be 0
  - LDD/STD: addr[2:0] must be 0
  - On violation, MEM_align_trap pulses for the accept cycle, with no stall and no request.
- FSM states:
  - IDLE: on a supported op with valid alignment, latch op3/addr/data, assert MEM_stall, go to REQ. Beat = 0.
  - REQ: mem_req = 1 with stable addr/we/be/wdata. On mem_gnt, go to WAIT.
  - WAIT: on mem_rvalid, capture the word. If the op is a double and beat 0, set beat = 1, addr += 4, go to REQ. Otherwise go to DONE.
  - DONE: MEM_done = 1, MEM_stall = 0, go to IDLE.
- MEM_stall = (IDLE and accepting) or REQ or WAIT.
- Store lanes:
  - STB: be = 4'b1000 >> addr[1:0]; byte replicated in all lanes.
  - STH: be = 1100 (addr[1] = 0) or 0011; half replicated.
  - ST: be = 1111, wdata = data[31:0].
  - STD: beat 0 = data[63:32] @ addr, beat 1 = data[31:0] @ addr+4.
- Loads: mem_we = 0, be = 1111. Result formatting:
  - byte ops: {56'b0, selected byte}, with offset 0 = rdata[31:24]
  - half ops: {48'b0, half}
  - LD: {32'b0, word}
  - LDD: {word@addr, word@addr+4}
- Store completion also yields MEM_done. MEM_load_data_out is unchanged on stores.
- MEM_load_data_out holds its value until the next load capture.
- mem_rvalid in IDLE, REQ or DONE is ignored.

## Timing
- Reset (async, active-low): state = IDLE. All outputs = 0, MEM_load_data_out = 0. mem_req drops immediately. Reset mid-access abandons it; a late mem_rvalid is ignored.
- Minimum single access, with gnt in the first REQ cycle and rvalid one cycle later:
  - accept at cycle 0, REQ at cycle 1, WAIT at cycle 2 (rvalid), DONE at cycle 3
  - MEM_stall high for cycles 0–2
- Double access minimum: DONE at cycle 5.
- mem_gnt wait states: REQ holds all request signals stable. Each gnt-low cycle adds one cycle.
- mem_rvalid arrives no earlier than the cycle after gnt. Each absent cycle in WAIT adds one cycle.
- In IDLE, MEM_done and a new accept may not overlap, so back-to-back memory ops are spaced by the DONE cycle.

## Structure
- `sparc_pkg`: op3 localparams (LD = 6'b000000, LDUB = 000001, LDUH = 000010, LDD = 000011, ST = 000100, STB = 000101, STH = 000110, STD = 000111, LDSB = 001001, LDSH = 001010); `mem_state_t` enum; is_load/is_store/is_double functions.
- Sub-module `mem_lane_fmt`, combinational:
  - store: op3 + offset + data → be/wdata
  - load: op3 + offset + rdata → formatted load slice

## Test plan
- LDUB @ 0x1003, rdata 0xAABBCCDD, gnt immediate, rvalid +1 → MEM_load_data_out = 0x00000000000000DD, MEM_done at cycle 3, stall cycles 0–2.
- LDD @ 0x2000, rdata 0x11111111 then 0x22222222 → mem_addr 0x2000 then 0x2004; result 0x1111111122222222; MEM_done at cycle 5.
- STH @ 0x3002, data[15:0] = 0xBEEF, gnt delayed 3 cycles → mem_be = 0011, mem_wdata = 0xBEEFBEEF, request stable for all 4 REQ cycles.
- LD @ 0x4002 → MEM_align_trap pulse, mem_req never asserted, MEM_stall = 0.
- STD @ 0x5000 with reset asserted while in WAIT of beat 1 → mem_req = 0 and all outputs 0 immediately; later rvalid ignored; state IDLE.
- ADD (op = 2'b10) with MEM_valid_in = 1 → no stall, no request, MEM_load_data_out unchanged.

Source files
------------

// File: rtl/sparc_pkg.sv
// SPARC memory-op encodings, load/store FSM state type and op3 classification helpers
// shared by the memory-stage load/store unit.
package sparc_pkg;

    localparam logic [1:0] OP_MEM    = 2'b11;

    localparam logic [5:0] OP3_LD    = 6'b000000;
    localparam logic [5:0] OP3_LDUB  = 6'b000001;
    localparam logic [5:0] OP3_LDUH  = 6'b000010;
    localparam logic [5:0] OP3_LDD   = 6'b000011;
    localparam logic [5:0] OP3_ST    = 6'b000100;
    localparam logic [5:0] OP3_STB   = 6'b000101;
    localparam logic [5:0] OP3_STH   = 6'b000110;
    localparam logic [5:0] OP3_STD   = 6'b000111;
    localparam logic [5:0] OP3_LDSB  = 6'b001001;
    localparam logic [5:0] OP3_LDSH  = 6'b001010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10,
        ST_DONE = 2'b11
    } mem_state_t;

    function automatic logic is_load(input logic [5:0] op3);
        case (op3)
            OP3_LD, OP3_LDUB, OP3_LDUH, OP3_LDD, OP3_LDSB, OP3_LDSH: is_load = 1'b1;
            default:                                                is_load = 1'b0;
        endcase
    endfunction

    function automatic logic is_store(input logic [5:0] op3);
        case (op3)
            OP3_ST, OP3_STB, OP3_STH, OP3_STD: is_store = 1'b1;
            default:                           is_store = 1'b0;
        endcase
    endfunction

    function automatic logic is_double(input logic [5:0] op3);
        is_double = (op3 == OP3_LDD) || (op3 == OP3_STD);
    endfunction

    function automatic logic is_half(input logic [5:0] op3);
        is_half = (op3 == OP3_LDUH) || (op3 == OP3_LDSH) || (op3 == OP3_STH);
    endfunction

    function automatic logic is_byte(input logic [5:0] op3);
        is_byte = (op3 == OP3_LDUB) || (op3 == OP3_LDSB) || (op3 == OP3_STB);
    endfunction

    function automatic logic is_mem_op(input logic [5:0] op3);
        is_mem_op = is_load(op3) || is_store(op3);
    endfunction

    // Natural alignment: bytes anywhere, halves on 2, words on 4, doubles on 8.
    function automatic logic is_aligned(input logic [5:0] op3, input logic [2:0] off);
        if (is_double(op3)) begin
            is_aligned = (off == 3'b000);
        end else if (is_half(op3)) begin
            is_aligned = (off[0] == 1'b0);
        end else if (is_byte(op3)) begin
            is_aligned = 1'b1;
        end else begin
            is_aligned = (off[1:0] == 2'b00);
        end
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// Request/response data-memory port of the load/store unit; master = load/store unit,
// slave = memory.
interface mem_access_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/mem_lane_fmt.sv
// Big-endian byte-lane steering: store byte enables / replicated write data, and
// right-justified raw load slices from a 32-bit memory word.
module mem_lane_fmt
    import sparc_pkg::*;
(
    input  logic [5:0]  op3,
    input  logic [1:0]  offset,
    input  logic [31:0] st_word,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] ld_slice
);

    // Store lane enables and write data; loads always read the full word.
    always_comb begin
        be    = 4'b0000;
        wdata = 32'h0000_0000;
        case (op3)
            OP3_STB: begin
                be    = 4'b1000 >> offset;
                wdata = {4{st_word[7:0]}};
            end
            OP3_STH: begin
                be    = offset[1] ? 4'b0011 : 4'b1100;
                wdata = {2{st_word[15:0]}};
            end
            OP3_ST, OP3_STD: begin
                be    = 4'b1111;
                wdata = st_word;
            end
            OP3_LD, OP3_LDUB, OP3_LDUH, OP3_LDD, OP3_LDSB, OP3_LDSH: begin
                be    = 4'b1111;
                wdata = 32'h0000_0000;
            end
            default: begin
                be    = 4'b0000;
                wdata = 32'h0000_0000;
            end
        endcase
    end

    // Load slice selection; byte offset 0 is the most significant lane.
    always_comb begin
        ld_slice = 32'h0000_0000;
        case (op3)
            OP3_LDUB, OP3_LDSB: begin
                case (offset)
                    2'b00:   ld_slice = {24'h00_0000, rdata[31:24]};
                    2'b01:   ld_slice = {24'h00_0000, rdata[23:16]};
                    2'b10:   ld_slice = {24'h00_0000, rdata[15:8]};
                    2'b11:   ld_slice = {24'h00_0000, rdata[7:0]};
                    default: ld_slice = 32'h0000_0000;
                endcase
            end
            OP3_LDUH, OP3_LDSH: begin
                if (offset[1]) begin
                    ld_slice = {16'h0000, rdata[15:0]};
                end else begin
                    ld_slice = {16'h0000, rdata[31:16]};
                end
            end
            OP3_LD, OP3_LDD: ld_slice = rdata;
            default:         ld_slice = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Memory-stage load/store unit: one memory instruction at a time over a req/gnt/rvalid
// data port, stalling IF/ID/EX while the access is in flight.
module mem_access
    import sparc_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               MEM_valid_in,
    input  logic [1:0]         MEM_op_in,
    input  logic [5:0]         MEM_op3_in,
    input  logic [31:0]        MEM_addr_in,
    input  logic [63:0]        MEM_store_data_in,
    output logic               MEM_stall,
    output logic               MEM_done,
    output logic               MEM_align_trap,
    output logic [63:0]        MEM_load_data_out,
    mem_access_if.master       mem
);

    mem_state_t  state_r;
    mem_state_t  state_nxt_s;

    logic [5:0]  op3_r;
    logic [1:0]  offset_r;
    logic [31:0] data_lo_r;
    logic        beat_r;
    logic [31:0] req_addr_r;
    logic        req_we_r;
    logic [3:0]  req_be_r;
    logic [31:0] req_wdata_r;
    logic [31:0] hi_word_r;
    logic [63:0] load_r;

    logic        mem_op_s;
    logic        aligned_s;
    logic        accept_s;
    logic        trap_s;
    logic        advance_s;
    logic        finish_s;

    logic [5:0]  fmt_op3_s;
    logic [1:0]  fmt_off_s;
    logic [31:0] fmt_st_s;
    logic [3:0]  fmt_be_s;
    logic [31:0] fmt_wdata_s;
    logic [31:0] fmt_ld_s;

    // Instruction decode, acceptance and beat sequencing strobes.
    always_comb begin
        mem_op_s  = reset && MEM_valid_in && (MEM_op_in == OP_MEM) && is_mem_op(MEM_op3_in);
        aligned_s = is_aligned(MEM_op3_in, MEM_addr_in[2:0]);
        accept_s  = (state_r == ST_IDLE) && mem_op_s && aligned_s;
        trap_s    = (state_r == ST_IDLE) && mem_op_s && !aligned_s;
        advance_s = (state_r == ST_WAIT) && mem.mem_rvalid && is_double(op3_r) && !beat_r;
        finish_s  = (state_r == ST_WAIT) && mem.mem_rvalid && !advance_s;
    end

    // Lane formatter sees the incoming instruction at accept and the latched one afterwards.
    always_comb begin
        if (state_r == ST_IDLE) begin
            fmt_op3_s = MEM_op3_in;
            fmt_off_s = MEM_addr_in[1:0];
            fmt_st_s  = is_double(MEM_op3_in) ? MEM_store_data_in[63:32]
                                              : MEM_store_data_in[31:0];
        end else begin
            fmt_op3_s = op3_r;
            fmt_off_s = offset_r;
            fmt_st_s  = data_lo_r;
        end
    end

    mem_lane_fmt u_lane_fmt (
        .op3      (fmt_op3_s),
        .offset   (fmt_off_s),
        .st_word  (fmt_st_s),
        .rdata    (mem.mem_rdata),
        .be       (fmt_be_s),
        .wdata    (fmt_wdata_s),
        .ld_slice (fmt_ld_s)
    );

    // Next-state logic of the access FSM.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_REQ;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (mem.mem_gnt) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (advance_s) begin
                    state_nxt_s = ST_REQ;
                end else if (finish_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Request registers are loaded once per beat so they stay stable through gnt wait states.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op3_r       <= 6'b000000;
            offset_r    <= 2'b00;
            data_lo_r   <= 32'h0000_0000;
            beat_r      <= 1'b0;
            req_addr_r  <= 32'h0000_0000;
            req_we_r    <= 1'b0;
            req_be_r    <= 4'b0000;
            req_wdata_r <= 32'h0000_0000;
            hi_word_r   <= 32'h0000_0000;
            load_r      <= 64'h0000_0000_0000_0000;
        end else if (accept_s) begin
            op3_r       <= MEM_op3_in;
            offset_r    <= MEM_addr_in[1:0];
            data_lo_r   <= MEM_store_data_in[31:0];
            beat_r      <= 1'b0;
            req_addr_r  <= {MEM_addr_in[31:2], 2'b00};
            req_we_r    <= is_store(MEM_op3_in);
            req_be_r    <= fmt_be_s;
            req_wdata_r <= fmt_wdata_s;
        end else if (advance_s) begin
            beat_r      <= 1'b1;
            req_addr_r  <= req_addr_r + 32'd4;
            req_be_r    <= fmt_be_s;
            req_wdata_r <= fmt_wdata_s;
            hi_word_r   <= mem.mem_rdata;
        end else if (finish_s && is_load(op3_r)) begin
            if (is_double(op3_r)) begin
                load_r <= {hi_word_r, mem.mem_rdata};
            end else begin
                load_r <= {32'h0000_0000, fmt_ld_s};
            end
        end
    end

    assign MEM_stall         = accept_s || (state_r == ST_REQ) || (state_r == ST_WAIT);
    assign MEM_done          = (state_r == ST_DONE);
    assign MEM_align_trap    = trap_s;
    assign MEM_load_data_out = load_r;

    assign mem.mem_req   = (state_r == ST_REQ);
    assign mem.mem_we    = req_we_r;
    assign mem.mem_addr  = req_addr_r;
    assign mem.mem_be    = req_be_r;
    assign mem.mem_wdata = req_wdata_r;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: scripted memory responder plus a load-result scoreboard.
`timescale 1ns/1ps
module tb_mem_access;
    import sparc_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid;
    logic [1:0]  op;
    logic [5:0]  op3;
    logic [31:0] addr;
    logic [63:0] sdata;
    logic        stall;
    logic        done;
    logic        trap;
    logic [63:0] ld_out;

    mem_access_if mem_bus();

    mem_access dut (
        .clk               (clk),
        .reset             (reset),
        .MEM_valid_in      (valid),
        .MEM_op_in         (op),
        .MEM_op3_in        (op3),
        .MEM_addr_in       (addr),
        .MEM_store_data_in (sdata),
        .MEM_stall         (stall),
        .MEM_done          (done),
        .MEM_align_trap    (trap),
        .MEM_load_data_out (ld_out),
        .mem               (mem_bus)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    logic [63:0] exp_q[$];
    logic [63:0] got_q[$];
    logic [31:0] rdata_q[$];
    int          gnt_delay;
    int          gnt_left;
    bit          rv_pending;
    bit          rv_block;
    bit          stall_h[$];
    bit          done_h[$];
    bit          trap_h[$];
    bit          req_h[$];
    logic [31:0] raddr_h[$];
    logic [31:0] rwdata_h[$];
    logic [3:0]  rbe_h[$];
    logic        rwe_h[$];
    logic [63:0] last_load;

    task automatic drive(input logic v, input logic [1:0] o, input logic [5:0] o3,
                         input logic [31:0] a, input logic [63:0] d);
        valid = v; op = o; op3 = o3; addr = a; sdata = d;
    endtask

    task automatic clear_logs();
        stall_h.delete(); done_h.delete(); trap_h.delete(); req_h.delete();
        raddr_h.delete(); rwdata_h.delete(); rbe_h.delete(); rwe_h.delete();
        got_q.delete();
        gnt_left   = gnt_delay;
        rv_pending = 1'b0;
    endtask

    // One clock cycle: respond as memory, then record observations at the falling edge.
    task automatic cycle();
        #2;
        mem_bus.mem_gnt    = 1'b0;
        mem_bus.mem_rvalid = 1'b0;
        mem_bus.mem_rdata  = 32'h0;
        if (rv_pending && !rv_block) begin
            mem_bus.mem_rvalid = 1'b1;
            if (rdata_q.size() > 0) mem_bus.mem_rdata = rdata_q.pop_front();
            rv_pending = 1'b0;
        end else if (mem_bus.mem_req && !rv_pending) begin
            if (gnt_left == 0) begin
                mem_bus.mem_gnt = 1'b1;
                rv_pending      = 1'b1;
                gnt_left        = gnt_delay;
            end else begin
                gnt_left--;
            end
        end
        #2;
        stall_h.push_back(stall);
        done_h.push_back(done);
        trap_h.push_back(trap);
        req_h.push_back(mem_bus.mem_req);
        if (mem_bus.mem_req) begin
            raddr_h.push_back(mem_bus.mem_addr);
            rwdata_h.push_back(mem_bus.mem_wdata);
            rbe_h.push_back(mem_bus.mem_be);
            rwe_h.push_back(mem_bus.mem_we);
        end
        if (done) got_q.push_back(ld_out);
        @(posedge clk);
        #1;
    endtask

    task automatic run_until_done(input int bound, output int done_at);
        bit seen;
        seen    = 1'b0;
        done_at = -1;
        for (int i = 0; i < bound && !seen; i++) begin
            cycle();
            if (done_h[done_h.size()-1]) begin
                seen    = 1'b1;
                done_at = done_h.size() - 1;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(1'b0, 2'b00, 6'b000000, 32'h0, 64'h0);
        mem_bus.mem_gnt = 1'b0; mem_bus.mem_rvalid = 1'b0; mem_bus.mem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #3;
        checks++;
        if ({stall, done, trap, mem_bus.mem_req, mem_bus.mem_we} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=00000", {stall, done, trap, mem_bus.mem_req, mem_bus.mem_we});
        end
        checks++;
        if ({mem_bus.mem_addr, mem_bus.mem_be, mem_bus.mem_wdata} !== 68'h0) begin
            failures++;
            $display("FAIL reset_bus got=%h/%b/%h exp=0", mem_bus.mem_addr, mem_bus.mem_be, mem_bus.mem_wdata);
        end
        checks++;
        if (ld_out !== 64'h0) begin
            failures++;
            $display("FAIL reset_load got=%h exp=0", ld_out);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_ldub();
        int d;
        logic [3:0] sp;
        logic [63:0] e;
        clear_logs();
        rdata_q.push_back(32'hAABBCCDD);
        exp_q.push_back(64'h0000_0000_0000_00DD);
        drive(1'b1, 2'b11, OP3_LDUB, 32'h0000_1003, 64'h0);
        cycle();
        valid = 1'b0;
        run_until_done(20, d);
        checks++;
        if (d !== 3) begin failures++; $display("FAIL ldub_done_cycle got=%0d exp=3", d); end
        sp = 4'bxxxx;
        for (int i = 0; i < 4 && i < stall_h.size(); i++) sp[3-i] = stall_h[i];
        checks++;
        if (sp !== 4'b1110) begin failures++; $display("FAIL ldub_stall got=%b exp=1110", sp); end
        checks++;
        if (raddr_h.size() != 1) begin
            failures++; $display("FAIL ldub_req_count got=%0d exp=1", raddr_h.size());
        end else if (raddr_h[0] !== 32'h0000_1000 || rbe_h[0] !== 4'b1111 || rwe_h[0] !== 1'b0) begin
            failures++;
            $display("FAIL ldub_req got addr=%h be=%b we=%b exp addr=00001000 be=1111 we=0", raddr_h[0], rbe_h[0], rwe_h[0]);
        end
        e = exp_q.pop_front();
        checks++;
        if (got_q.size() == 0) begin failures++; $display("FAIL ldub_data got=none exp=%h", e); end
        else if (got_q[0] !== e) begin failures++; $display("FAIL ldub_data got=%h exp=%h", got_q[0], e); end
        last_load = e;
    endtask

    task automatic test_ldd();
        int d;
        logic [63:0] e;
        clear_logs();
        rdata_q.push_back(32'h1111_1111);
        rdata_q.push_back(32'h2222_2222);
        exp_q.push_back(64'h1111_1111_2222_2222);
        drive(1'b1, 2'b11, OP3_LDD, 32'h0000_2000, 64'h0);
        cycle();
        valid = 1'b0;
        run_until_done(30, d);
        checks++;
        if (d !== 5) begin failures++; $display("FAIL ldd_done_cycle got=%0d exp=5", d); end
        checks++;
        if (raddr_h.size() != 2) begin
            failures++; $display("FAIL ldd_req_count got=%0d exp=2", raddr_h.size());
        end else if (raddr_h[0] !== 32'h0000_2000 || raddr_h[1] !== 32'h0000_2004) begin
            failures++; $display("FAIL ldd_addr got=%h,%h exp=00002000,00002004", raddr_h[0], raddr_h[1]);
        end
        e = exp_q.pop_front();
        checks++;
        if (got_q.size() == 0) begin failures++; $display("FAIL ldd_data got=none exp=%h", e); end
        else if (got_q[0] !== e) begin failures++; $display("FAIL ldd_data got=%h exp=%h", got_q[0], e); end
        last_load = e;
    endtask

    task automatic test_sth_wait();
        int d;
        int bad;
        logic [63:0] e;
        gnt_delay = 3;
        clear_logs();
        exp_q.push_back(last_load);
        drive(1'b1, 2'b11, OP3_STH, 32'h0000_3002, 64'h0000_0000_1234_BEEF);
        cycle();
        valid = 1'b0;
        run_until_done(30, d);
        gnt_delay = 0;
        checks++;
        if (d !== 6) begin failures++; $display("FAIL sth_done_cycle got=%0d exp=6", d); end
        bad = 0;
        for (int i = 0; i < raddr_h.size(); i++) begin
            if (raddr_h[i] !== 32'h0000_3000 || rbe_h[i] !== 4'b0011 ||
                rwdata_h[i] !== 32'hBEEF_BEEF || rwe_h[i] !== 1'b1) bad++;
        end
        checks++;
        if (raddr_h.size() != 4 || bad != 0) begin
            failures++;
            $display("FAIL sth_req got cycles=%0d unstable=%0d exp cycles=4 unstable=0", raddr_h.size(), bad);
        end
        e = exp_q.pop_front();
        checks++;
        if (got_q.size() == 0) begin failures++; $display("FAIL sth_load_hold got=none exp=%h", e); end
        else if (got_q[0] !== e) begin failures++; $display("FAIL sth_load_hold got=%h exp=%h", got_q[0], e); end
    endtask

    task automatic test_store_lanes();
        logic [5:0]  t_op3 [4];
        logic [31:0] t_ad  [4];
        logic [63:0] t_d   [4];
        logic [3:0]  t_be  [4];
        logic [31:0] t_wd  [4];
        int d;
        t_op3 = '{OP3_STB, OP3_STB, OP3_ST, OP3_STH};
        t_ad  = '{32'h0000_7001, 32'h0000_7003, 32'h0000_7004, 32'h0000_7000};
        t_d   = '{64'h0000_0000_0000_005A, 64'h0000_0000_0000_00C3,
                  64'h0000_0000_0123_4567, 64'h0000_0000_0000_A55A};
        t_be  = '{4'b0100, 4'b0001, 4'b1111, 4'b1100};
        t_wd  = '{32'h5A5A_5A5A, 32'hC3C3_C3C3, 32'h0123_4567, 32'hA55A_A55A};
        for (int i = 0; i < 4; i++) begin
            clear_logs();
            drive(1'b1, 2'b11, t_op3[i], t_ad[i], t_d[i]);
            cycle();
            valid = 1'b0;
            run_until_done(20, d);
            checks++;
            if (raddr_h.size() != 1 || d !== 3) begin
                failures++;
                $display("FAIL lane_%0d_timing got reqs=%0d done=%0d exp reqs=1 done=3", i, raddr_h.size(), d);
            end else if (rbe_h[0] !== t_be[i] || rwdata_h[0] !== t_wd[i] ||
                         raddr_h[0] !== {t_ad[i][31:2], 2'b00} || rwe_h[0] !== 1'b1) begin
                failures++;
                $display("FAIL lane_%0d got be=%b wdata=%h addr=%h we=%b exp be=%b wdata=%h", i,
                         rbe_h[0], rwdata_h[0], raddr_h[0], rwe_h[0], t_be[i], t_wd[i]);
            end
        end
        checks++;
        if (ld_out !== last_load) begin failures++; $display("FAIL lane_load_hold got=%h exp=%h", ld_out, last_load); end
    endtask

    task automatic test_align();
        logic [5:0]  t_op3 [4];
        logic [31:0] t_ad  [4];
        t_op3 = '{OP3_LD, OP3_LDSH, OP3_STD, OP3_ST};
        t_ad  = '{32'h0000_4002, 32'h0000_4001, 32'h0000_4004, 32'h0000_4001};
        for (int i = 0; i < 4; i++) begin
            clear_logs();
            drive(1'b1, 2'b11, t_op3[i], t_ad[i], 64'h0);
            cycle();
            valid = 1'b0;
            cycle();
            cycle();
            checks++;
            if (trap_h[0] !== 1'b1 || stall_h[0] !== 1'b0 || trap_h[1] !== 1'b0 ||
                req_h.sum() with (int'(item)) != 0) begin
                failures++;
                $display("FAIL align_%0d got trap=%b,%b stall=%b reqs=%0d exp trap=1,0 stall=0 reqs=0",
                         i, trap_h[0], trap_h[1], stall_h[0], req_h.sum() with (int'(item)));
            end
        end
        checks++;
        if (ld_out !== last_load) begin failures++; $display("FAIL align_load_hold got=%h exp=%h", ld_out, last_load); end
    endtask

    task automatic test_passthrough();
        logic [1:0] t_op  [2];
        logic [5:0] t_op3 [2];
        t_op  = '{2'b10, 2'b11};
        t_op3 = '{6'b000000, 6'b001101};
        for (int i = 0; i < 2; i++) begin
            clear_logs();
            drive(1'b1, t_op[i], t_op3[i], 32'h0000_8000, 64'h0);
            repeat (3) cycle();
            valid = 1'b0;
            checks++;
            if ((stall_h.sum() with (int'(item))) != 0 || (req_h.sum() with (int'(item))) != 0 ||
                (trap_h.sum() with (int'(item))) != 0 || ld_out !== last_load) begin
                failures++;
                $display("FAIL pass_%0d got stalls=%0d reqs=%0d load=%h exp stalls=0 reqs=0 load=%h", i,
                         stall_h.sum() with (int'(item)), req_h.sum() with (int'(item)), ld_out, last_load);
            end
        end
    endtask

    task automatic test_back_to_back();
        int d;
        logic [63:0] e;
        clear_logs();
        rdata_q.push_back(32'h80FF_7F01);
        rdata_q.push_back(32'h80FF_7F01);
        exp_q.push_back(64'h0000_0000_0000_00FF);
        exp_q.push_back(64'h0000_0000_0000_7F01);
        drive(1'b1, 2'b11, OP3_LDSB, 32'h0000_6001, 64'h0);
        cycle();
        valid = 1'b0;
        cycle();
        cycle();
        drive(1'b1, 2'b11, OP3_LDSH, 32'h0000_6002, 64'h0);
        cycle();
        checks++;
        if (done_h[3] !== 1'b1 || stall_h[3] !== 1'b0) begin
            failures++; $display("FAIL b2b_done_gap got done=%b stall=%b exp done=1 stall=0", done_h[3], stall_h[3]);
        end
        cycle();
        valid = 1'b0;
        checks++;
        if (stall_h[4] !== 1'b1) begin failures++; $display("FAIL b2b_accept got stall=%b exp=1", stall_h[4]); end
        run_until_done(20, d);
        checks++;
        if (d !== 7) begin failures++; $display("FAIL b2b_done_cycle got=%0d exp=7", d); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (got_q.size() == 0) begin failures++; $display("FAIL b2b_data got=none exp=%h", e); end
            else begin
                if (got_q[0] !== e) begin failures++; $display("FAIL b2b_data got=%h exp=%h", got_q[0], e); end
                void'(got_q.pop_front());
            end
            last_load = e;
        end
    endtask

    task automatic test_reset_mid();
        clear_logs();
        drive(1'b1, 2'b11, OP3_STD, 32'h0000_5000, 64'hCAFE_F00D_1234_5678);
        cycle();
        valid = 1'b0;
        cycle();
        cycle();
        cycle();
        rv_block = 1'b1;
        cycle();
        checks++;
        if (stall_h[4] !== 1'b1 || req_h[4] !== 1'b0) begin
            failures++; $display("FAIL rmid_in_wait got stall=%b req=%b exp stall=1 req=0", stall_h[4], req_h[4]);
        end
        checks++;
        if (raddr_h.size() != 2) begin
            failures++; $display("FAIL rmid_beats got=%0d exp=2", raddr_h.size());
        end else if (raddr_h[0] !== 32'h0000_5000 || rwdata_h[0] !== 32'hCAFE_F00D ||
                     raddr_h[1] !== 32'h0000_5004 || rwdata_h[1] !== 32'h1234_5678) begin
            failures++;
            $display("FAIL rmid_beats got %h:%h %h:%h exp 00005000:cafef00d 00005004:12345678",
                     raddr_h[0], rwdata_h[0], raddr_h[1], rwdata_h[1]);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({stall, done, trap, mem_bus.mem_req, mem_bus.mem_we} !== 5'b0 ||
            {mem_bus.mem_addr, mem_bus.mem_be, mem_bus.mem_wdata} !== 68'h0 || ld_out !== 64'h0) begin
            failures++;
            $display("FAIL rmid_reset_outputs got ctrl=%b addr=%h be=%b wdata=%h load=%h exp all 0",
                     {stall, done, trap, mem_bus.mem_req, mem_bus.mem_we},
                     mem_bus.mem_addr, mem_bus.mem_be, mem_bus.mem_wdata, ld_out);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        last_load = 64'h0;
        clear_logs();
        rv_pending = 1'b1;
        rv_block   = 1'b0;
        repeat (3) cycle();
        checks++;
        if ((done_h.sum() with (int'(item))) != 0 || (stall_h.sum() with (int'(item))) != 0 ||
            (req_h.sum() with (int'(item))) != 0 || ld_out !== last_load) begin
            failures++;
            $display("FAIL rmid_late_rvalid got dones=%0d stalls=%0d reqs=%0d load=%h exp 0/0/0/%h",
                     done_h.sum() with (int'(item)), stall_h.sum() with (int'(item)),
                     req_h.sum() with (int'(item)), ld_out, last_load);
        end
    endtask

    initial begin
        gnt_delay  = 0;
        gnt_left   = 0;
        rv_pending = 1'b0;
        rv_block   = 1'b0;
        last_load  = 64'h0;
        test_reset();
        test_ldub();
        test_ldd();
        test_sth_wait();
        test_store_lanes();
        test_align();
        test_passthrough();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
